// File: rtl/mips_pkg.sv
// Shared writeback-stage encodings for the MIPS core: result-source selects,
// load opcodes and the DW-dependent lane-offset width.
package mips_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_MEM  = 2'd1;
   localparam logic [1:0] WB_SEL_PC8  = 2'd2;
   localparam logic [1:0] WB_SEL_NONE = 2'd3;

   localparam logic [2:0] LDOP_LW  = 3'd0;
   localparam logic [2:0] LDOP_LH  = 3'd1;
   localparam logic [2:0] LDOP_LHU = 3'd2;
   localparam logic [2:0] LDOP_LB  = 3'd3;
   localparam logic [2:0] LDOP_LBU = 3'd4;
   localparam logic [2:0] LDOP_LWU = 3'd5;
   localparam logic [2:0] LDOP_LD  = 3'd6;

   // Number of address bits that pick a byte lane inside one DW-wide memory word.
   function automatic int laneOffW(input int dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/load_ext.sv
// Load lane selection and sign/zero extension for the writeback stage.
// Misaligned accesses fall back to the aligned-down lane and raise misalign_o.
module load_ext
   import mips_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [2:0]                ldop_i,
   input  logic [laneOffW(DW)-1:0]   off_i,
   input  logic [DW-1:0]             memrd_i,
   output logic [DW-1:0]             data_o,
   output logic                      misalign_o
);

   localparam int  OFFW = laneOffW(DW);
   localparam bit  WIDE = (DW == 64);

   logic [OFFW-1:0] offH;
   logic [OFFW-1:0] offW;
   logic [7:0]      byteVal;
   logic [15:0]     halfVal;
   logic [31:0]     wordVal;

   always_comb begin
      offH    = off_i & ~OFFW'(1);
      offW    = off_i & ~OFFW'(3);
      byteVal = memrd_i[{off_i, 3'b000} +: 8];
      halfVal = memrd_i[{offH, 3'b000} +: 16];
      wordVal = memrd_i[{offW, 3'b000} +: 32];
   end

   // LWU and LD only exist on a 64-bit datapath; on 32 bits they behave as LW.
   always_comb begin
      data_o     = memrd_i;
      misalign_o = 1'b0;
      case (ldop_i)
         LDOP_LB:  data_o = DW'($signed(byteVal));
         LDOP_LBU: data_o = DW'(byteVal);
         LDOP_LH: begin
            data_o     = DW'($signed(halfVal));
            misalign_o = off_i[0];
         end
         LDOP_LHU: begin
            data_o     = DW'(halfVal);
            misalign_o = off_i[0];
         end
         LDOP_LW: begin
            data_o     = DW'($signed(wordVal));
            misalign_o = (off_i[1:0] != 2'b00);
         end
         LDOP_LWU: begin
            data_o     = WIDE ? DW'(wordVal) : DW'($signed(wordVal));
            misalign_o = (off_i[1:0] != 2'b00);
         end
         LDOP_LD: begin
            data_o     = WIDE ? memrd_i : DW'($signed(wordVal));
            misalign_o = WIDE ? (off_i != '0) : (off_i[1:0] != 2'b00);
         end
         default: data_o = memrd_i;
      endcase
   end

endmodule

// File: rtl/wb_stage_arb.sv
// Registered writeback stage: one-entry stage register, multiply/divide result
// FIFO, and arbitration of the single register-file write port between them.
module wb_stage_arb
   import mips_pkg::*;
#(
   parameter int DW        = 32,
   parameter int RF_AW     = 5,
   parameter int MDQ_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_pc,
   input  logic [RF_AW-1:0] in_wa,
   input  logic [1:0]       in_sel,
   input  logic [2:0]       in_ldop,
   input  logic [DW-1:0]    in_alu,
   input  logic [DW-1:0]    in_memrd,
   input  logic             md_valid,
   output logic             md_ready,
   input  logic [RF_AW-1:0] md_wa,
   input  logic [DW-1:0]    md_data,
   output logic             rf_we,
   output logic [RF_AW-1:0] rf_wa,
   output logic [DW-1:0]    rf_wd,
   output logic [31:0]      wb_pc,
   output logic             ld_misalign,
   output logic [31:0]      retire_cnt
);

   localparam int OFFW = laneOffW(DW);
   localparam int QAW  = $clog2(MDQ_DEPTH);
   localparam int CW   = QAW + 1;

   logic             stageValid_q, stageValid_d;
   logic [31:0]      stagePc_q,    stagePc_d;
   logic [RF_AW-1:0] stageWa_q,    stageWa_d;
   logic             stageWe_q,    stageWe_d;
   logic [DW-1:0]    stageWd_q,    stageWd_d;
   logic             stageMis_q,   stageMis_d;
   logic [31:0]      retireCnt_q,  retireCnt_d;

   logic [RF_AW-1:0] qWa_q   [MDQ_DEPTH];
   logic [DW-1:0]    qData_q [MDQ_DEPTH];
   logic [QAW-1:0]   rdPtr_q, rdPtr_d;
   logic [QAW-1:0]   wrPtr_q, wrPtr_d;
   logic [CW-1:0]    count_q, count_d;

   logic [DW-1:0]    ldData;
   logic             ldMis;
   logic [DW-1:0]    entryWd;
   logic             entryWe;
   logic             entryMis;
   logic             stageLive;
   logic             qEmpty;
   logic             qFull;
   logic             retire;
   logic             grantQ;
   logic             accept;
   logic             push;

   load_ext #(.DW(DW)) u_load_ext (
      .ldop_i     (in_ldop),
      .off_i      (in_alu[OFFW-1:0]),
      .memrd_i    (in_memrd),
      .data_o     (ldData),
      .misalign_o (ldMis)
   );

   always_comb begin
      entryWe  = (in_sel != WB_SEL_NONE) && (in_wa != '0);
      entryWd  = '0;
      entryMis = 1'b0;
      case (in_sel)
         WB_SEL_ALU: entryWd = in_alu;
         WB_SEL_MEM: begin
            entryWd  = ldData;
            entryMis = ldMis;
         end
         WB_SEL_PC8: entryWd = DW'(in_pc + 32'd8);
         default:    entryWd = '0;
      endcase
   end

   // A flushed entry is treated as already gone, so it neither writes nor retires.
   always_comb begin
      stageLive = stageValid_q && !flush;
      qEmpty    = (count_q == '0);
      qFull     = (count_q == CW'(MDQ_DEPTH));
      retire    = stageLive && !qFull;
      grantQ    = !qEmpty && (qFull || !stageLive);
      in_ready  = !stageValid_q || retire;
      md_ready  = !qFull;
      accept    = in_valid && in_ready && !flush;
      push      = md_valid && md_ready;
   end

   always_comb begin
      stageValid_d = stageValid_q;
      stagePc_d    = stagePc_q;
      stageWa_d    = stageWa_q;
      stageWe_d    = stageWe_q;
      stageWd_d    = stageWd_q;
      stageMis_d   = stageMis_q;
      if (accept) begin
         stageValid_d = 1'b1;
         stagePc_d    = in_pc;
         stageWa_d    = in_wa;
         stageWe_d    = entryWe;
         stageWd_d    = entryWd;
         stageMis_d   = entryMis;
      end else if (retire || flush) begin
         stageValid_d = 1'b0;
      end
      retireCnt_d = retireCnt_q + 32'(retire);
   end

   always_comb begin
      wrPtr_d = push   ? wrPtr_q + QAW'(1) : wrPtr_q;
      rdPtr_d = grantQ ? rdPtr_q + QAW'(1) : rdPtr_q;
      count_d = count_q + CW'(push) - CW'(grantQ);
   end

   always_comb begin
      rf_we       = 1'b0;
      rf_wa       = '0;
      rf_wd       = '0;
      wb_pc       = '0;
      ld_misalign = 1'b0;
      if (retire) begin
         rf_we       = stageWe_q;
         rf_wa       = stageWe_q ? stageWa_q : '0;
         rf_wd       = stageWe_q ? stageWd_q : '0;
         wb_pc       = stagePc_q;
         ld_misalign = stageMis_q;
      end else if (grantQ && (qWa_q[rdPtr_q] != '0)) begin
         rf_we = 1'b1;
         rf_wa = qWa_q[rdPtr_q];
         rf_wd = qData_q[rdPtr_q];
      end
   end

   assign retire_cnt = retireCnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stageValid_q <= 1'b0;
         stagePc_q    <= '0;
         stageWa_q    <= '0;
         stageWe_q    <= 1'b0;
         stageWd_q    <= '0;
         stageMis_q   <= 1'b0;
         retireCnt_q  <= '0;
         rdPtr_q      <= '0;
         wrPtr_q      <= '0;
         count_q      <= '0;
      end else begin
         stageValid_q <= stageValid_d;
         stagePc_q    <= stagePc_d;
         stageWa_q    <= stageWa_d;
         stageWe_q    <= stageWe_d;
         stageWd_q    <= stageWd_d;
         stageMis_q   <= stageMis_d;
         retireCnt_q  <= retireCnt_d;
         rdPtr_q      <= rdPtr_d;
         wrPtr_q      <= wrPtr_d;
         count_q      <= count_d;
      end
   end

   // Queue storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         qWa_q[wrPtr_q]   <= md_wa;
         qData_q[wrPtr_q] <= md_data;
      end
   end

endmodule

// File: tb/tb_wb_stage_arb.sv
// Directed bench for wb_stage_arb: table of load/ALU/JAL vectors streamed
// back-to-back, plus hand-written queue, flush and async-reset sequences.
module tb_wb_stage_arb;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        inValid;
   logic        inReady;
   logic [31:0] inPc;
   logic [4:0]  inWa;
   logic [1:0]  inSel;
   logic [2:0]  inLdop;
   logic [31:0] inAlu;
   logic [31:0] inMemrd;
   logic        mdValid;
   logic        mdReady;
   logic [4:0]  mdWa;
   logic [31:0] mdData;
   logic        rfWe;
   logic [4:0]  rfWa;
   logic [31:0] rfWd;
   logic [31:0] wbPc;
   logic        ldMisalign;
   logic [31:0] retireCnt;

   int checks = 0;
   int errors = 0;
   int retExp = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  wa;
      logic [1:0]  sel;
      logic [2:0]  ldop;
      logic [31:0] alu;
      logic [31:0] memrd;
      logic        expWe;
      logic [31:0] expWd;
      logic        expMis;
   } vec_t;

   localparam int N = 15;
   vec_t vecs [N];

   wb_stage_arb #(.DW(32), .RF_AW(5), .MDQ_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (inValid),
      .in_ready    (inReady),
      .in_pc       (inPc),
      .in_wa       (inWa),
      .in_sel      (inSel),
      .in_ldop     (inLdop),
      .in_alu      (inAlu),
      .in_memrd    (inMemrd),
      .md_valid    (mdValid),
      .md_ready    (mdReady),
      .md_wa       (mdWa),
      .md_data     (mdData),
      .rf_we       (rfWe),
      .rf_wa       (rfWa),
      .rf_wd       (rfWd),
      .wb_pc       (wbPc),
      .ld_misalign (ldMisalign),
      .retire_cnt  (retireCnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkVec(input logic [31:0] pc, input logic [4:0] wa,
                                  input logic [1:0] sel, input logic [2:0] ldop,
                                  input logic [31:0] alu, input logic [31:0] memrd,
                                  input logic expWe, input logic [31:0] expWd,
                                  input logic expMis);
      vec_t v;
      v.pc = pc; v.wa = wa; v.sel = sel; v.ldop = ldop; v.alu = alu; v.memrd = memrd;
      v.expWe = expWe; v.expWd = expWd; v.expMis = expMis;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      inValid = 1'b1;
      inPc    = v.pc;
      inWa    = v.wa;
      inSel   = v.sel;
      inLdop  = v.ldop;
      inAlu   = v.alu;
      inMemrd = v.memrd;
   endtask

   task automatic idleInputs();
      inValid = 1'b0; inPc = '0; inWa = '0; inSel = WB_SEL_NONE; inLdop = '0;
      inAlu = '0; inMemrd = '0; mdValid = 1'b0; mdWa = '0; mdData = '0; flush = 1'b0;
   endtask

   task automatic pushMd(input logic [4:0] wa, input logic [31:0] data);
      mdValid = 1'b1;
      mdWa    = wa;
      mdData  = data;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Stage entry v is on the write port this cycle and retires.
   task automatic checkEntry(input string name, input vec_t v);
      checkOutput({name, ".rf_we"}, 32'(rfWe), 32'(v.expWe));
      if (v.expWe) begin
         checkOutput({name, ".rf_wa"}, 32'(rfWa), 32'(v.wa));
         checkOutput({name, ".rf_wd"}, rfWd, v.expWd);
      end
      checkOutput({name, ".wb_pc"}, wbPc, v.pc);
      checkOutput({name, ".ld_misalign"}, 32'(ldMisalign), 32'(v.expMis));
      checkOutput({name, ".retire_cnt"}, retireCnt, 32'(retExp));
      retExp++;
   endtask

   // Queue head is on the write port; no pipeline entry retires.
   task automatic checkQueueWrite(input string name, input logic [4:0] wa, input logic [31:0] data);
      checkOutput({name, ".rf_we"}, 32'(rfWe), 32'd1);
      checkOutput({name, ".rf_wa"}, 32'(rfWa), 32'(wa));
      checkOutput({name, ".rf_wd"}, rfWd, data);
      checkOutput({name, ".wb_pc"}, wbPc, 32'd0);
      checkOutput({name, ".retire_cnt"}, retireCnt, 32'(retExp));
   endtask

   task automatic checkQuiet(input string name);
      checkOutput({name, ".rf_we"}, 32'(rfWe), 32'd0);
      checkOutput({name, ".wb_pc"}, wbPc, 32'd0);
      checkOutput({name, ".ld_misalign"}, 32'(ldMisalign), 32'd0);
      checkOutput({name, ".retire_cnt"}, retireCnt, 32'(retExp));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t a [5];
      vec_t b;

      vecs[0]  = mkVec(32'h0040_0100, 5'd8,  WB_SEL_MEM, LDOP_LB,  32'h1000_0003, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 1'b0);
      vecs[1]  = mkVec(32'h0040_0104, 5'd8,  WB_SEL_MEM, LDOP_LBU, 32'h1000_0003, 32'h80FF_0000, 1'b1, 32'h0000_0080, 1'b0);
      vecs[2]  = mkVec(32'h0040_0108, 5'd9,  WB_SEL_MEM, LDOP_LH,  32'h1000_0001, 32'h1234_8765, 1'b1, 32'hFFFF_8765, 1'b1);
      vecs[3]  = mkVec(32'h0040_010C, 5'd10, WB_SEL_MEM, LDOP_LHU, 32'h1000_0002, 32'h1234_8765, 1'b1, 32'h0000_1234, 1'b0);
      vecs[4]  = mkVec(32'h0040_0110, 5'd11, WB_SEL_MEM, LDOP_LW,  32'h1000_0000, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0);
      vecs[5]  = mkVec(32'h0040_0114, 5'd12, WB_SEL_MEM, LDOP_LW,  32'h1000_0006, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1);
      vecs[6]  = mkVec(32'h0040_0118, 5'd13, WB_SEL_MEM, LDOP_LH,  32'h1000_0002, 32'h8001_0000, 1'b1, 32'hFFFF_8001, 1'b0);
      vecs[7]  = mkVec(32'h0040_011C, 5'd14, WB_SEL_MEM, LDOP_LB,  32'h1000_0001, 32'h0000_7F00, 1'b1, 32'h0000_007F, 1'b0);
      vecs[8]  = mkVec(32'h0040_0010, 5'd31, WB_SEL_PC8, LDOP_LW,  32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0040_0018, 1'b0);
      vecs[9]  = mkVec(32'h0040_0124, 5'd0,  WB_SEL_ALU, LDOP_LW,  32'h0000_1234, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
      vecs[10] = mkVec(32'h0040_0128, 5'd5,  WB_SEL_ALU, LDOP_LW,  32'hA5A5_0001, 32'h0000_0000, 1'b1, 32'hA5A5_0001, 1'b0);
      vecs[11] = mkVec(32'h0040_012C, 5'd7,  WB_SEL_NONE, LDOP_LW, 32'h0000_5555, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
      vecs[12] = mkVec(32'h0040_0130, 5'd3,  WB_SEL_MEM, LDOP_LBU, 32'h1000_0004, 32'h0000_00FE, 1'b1, 32'h0000_00FE, 1'b0);
      vecs[13] = mkVec(32'h0040_0134, 5'd4,  WB_SEL_MEM, LDOP_LH,  32'h1000_0007, 32'hAAAA_7FFF, 1'b1, 32'hFFFF_AAAA, 1'b1);
      vecs[14] = mkVec(32'h0040_0138, 5'd6,  WB_SEL_MEM, LDOP_LBU, 32'h1000_0002, 32'h0042_0000, 1'b1, 32'h0000_0042, 1'b0);

      idleInputs();
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkQuiet("reset");
      checkOutput("reset.rf_wa", 32'(rfWa), 32'd0);
      checkOutput("reset.rf_wd", rfWd, 32'd0);
      checkOutput("reset.in_ready", 32'(inReady), 32'd1);
      checkOutput("reset.md_ready", 32'(mdReady), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      nextCycle();

      // Table vectors streamed back-to-back; each is checked the cycle after it is driven.
      for (int i = 0; i <= N; i++) begin
         if (i < N) applyStimulus(vecs[i]);
         else idleInputs();
         #1;
         if (i > 0) begin
            checkEntry($sformatf("vec%0d", i - 1), vecs[i - 1]);
            checkOutput($sformatf("vec%0d.in_ready", i - 1), 32'(inReady), 32'd1);
         end
         nextCycle();
      end
      #1;
      checkQuiet("table_idle");

      // Queue fills while the stage streams; the full queue steals one slot.
      for (int k = 0; k < 5; k++)
         a[k] = mkVec(32'h0050_0000 + 32'(4 * k), 5'(20 + k), WB_SEL_ALU, LDOP_LW,
                      32'h0A00_0000 + 32'(k), 32'h0, 1'b1, 32'h0A00_0000 + 32'(k), 1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(a[k]);
         pushMd(5'(k + 1), 32'h1110_0000 + 32'(k + 1));
         #1;
         checkOutput($sformatf("mdfill%0d.md_ready", k), 32'(mdReady), 32'd1);
         if (k > 0) checkEntry($sformatf("stream%0d", k - 1), a[k - 1]);
         nextCycle();
      end
      applyStimulus(a[4]);
      mdValid = 1'b0;
      #1;
      checkOutput("qfull.md_ready", 32'(mdReady), 32'd0);
      checkOutput("qfull.in_ready", 32'(inReady), 32'd0);
      checkQueueWrite("qfull.head", 5'd1, 32'h1110_0001);
      nextCycle();
      #1;
      checkOutput("qdrain.in_ready", 32'(inReady), 32'd1);
      checkOutput("qdrain.md_ready", 32'(mdReady), 32'd1);
      checkEntry("stream3", a[3]);
      nextCycle();
      idleInputs();
      #1;
      checkEntry("stream4", a[4]);
      nextCycle();
      for (int k = 2; k <= 4; k++) begin
         #1;
         checkQueueWrite($sformatf("qpop%0d", k), 5'(k), 32'h1110_0000 + 32'(k));
         nextCycle();
      end
      #1;
      checkQuiet("qempty");

      // Flush kills the held entry and blocks the same-cycle acceptance.
      b = mkVec(32'h0060_0000, 5'd6, WB_SEL_ALU, LDOP_LW, 32'h0000_5555, 32'h0, 1'b1, 32'h0000_5555, 1'b0);
      applyStimulus(b);
      nextCycle();
      b = mkVec(32'h0060_0004, 5'd7, WB_SEL_ALU, LDOP_LW, 32'h0000_7777, 32'h0, 1'b1, 32'h0000_7777, 1'b0);
      applyStimulus(b);
      flush = 1'b1;
      #1;
      checkQuiet("flush_cycle");
      nextCycle();
      idleInputs();
      #1;
      checkQuiet("flush_next");
      nextCycle();
      #1;
      checkQuiet("flush_after");

      // Asynchronous reset in the middle of traffic clears everything immediately.
      b = mkVec(32'h0070_0000, 5'd2, WB_SEL_ALU, LDOP_LW, 32'h0000_0D0D, 32'h0, 1'b1, 32'h0000_0D0D, 1'b0);
      applyStimulus(b);
      pushMd(5'd9, 32'h9999_0009);
      nextCycle();
      applyStimulus(mkVec(32'h0070_0004, 5'd3, WB_SEL_ALU, LDOP_LW, 32'h0000_0E0E, 32'h0, 1'b1, 32'h0000_0E0E, 1'b0));
      pushMd(5'd10, 32'hAAAA_000A);
      #1;
      checkEntry("prereset", b);
      #2;
      reset = 1'b0;
      retExp = 0;
      #1;
      checkQuiet("async_reset");
      checkOutput("async_reset.in_ready", 32'(inReady), 32'd1);
      checkOutput("async_reset.md_ready", 32'(mdReady), 32'd1);
      idleInputs();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkQuiet("post_reset0");
      nextCycle();
      #1;
      checkQuiet("post_reset1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
